// File: rtl/acc_pkg.sv
// Shared definitions for the 16-bit multi-register accumulator processor.
// Used by the control unit, its opcode decoder and the datapath, so all of them
// agree on opcode values, accumulator source codes, ALU codes and the
// control FSM state encoding.
package acc_pkg;

    // Opcodes carried in IR[15:12]
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_LD   = 4'h2;
    localparam logic [3:0] OPC_ST   = 4'h3;
    localparam logic [3:0] OPC_ADD  = 4'h4;
    localparam logic [3:0] OPC_SUB  = 4'h5;
    localparam logic [3:0] OPC_AND  = 4'h6;
    localparam logic [3:0] OPC_OR   = 4'h7;
    localparam logic [3:0] OPC_MOVR = 4'h8;
    localparam logic [3:0] OPC_MOVA = 4'h9;
    localparam logic [3:0] OPC_BEQZ = 4'hA;
    localparam logic [3:0] OPC_JMP  = 4'hB;
    localparam logic [3:0] OPC_IN   = 4'hC;
    localparam logic [3:0] OPC_OUT  = 4'hD;
    localparam logic [3:0] OPC_ILL  = 4'hE;   // undefined, behaves as NOP
    localparam logic [3:0] OPC_HALT = 4'hF;

    // Accumulator source select
    localparam logic [1:0] ACC_SRC_ALU = 2'd0;
    localparam logic [1:0] ACC_SRC_IMM = 2'd1;  // imm, or Input_Data when in_sel
    localparam logic [1:0] ACC_SRC_MEM = 2'd2;
    localparam logic [1:0] ACC_SRC_REG = 2'd3;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Decoded instruction class, latched in DECODE and consumed in EXEC/MEM
    typedef struct packed {
        logic       acc_load;
        logic [1:0] acc_src;
        logic [2:0] alu_op;
        logic       reg_we;
        logic       out_load;
        logic       in_sel;
        logic       pc_load;          // unconditional jump
        logic       pc_load_if_zero;  // conditional on zero_flag in EXEC
        logic       illegal;
        logic       go_mem;           // LD/ST need a MEM cycle
        logic       mem_we;           // ST
        logic       mem_load;         // LD loads ACC when memory completes
        logic       go_halt;
    } ctrl_bundle_t;

    // ADD..OR are contiguous from 4, so the ALU code is the low opcode bits
    function automatic logic [2:0] alu_op_of(input logic [3:0] opc);
        return {1'b0, opc[1:0]};
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode decoder for the accumulator control unit.
// Maps a 4-bit opcode onto the bundle of strobes and flow-control hints the
// control FSM needs. Holds no state; the FSM latches the result in DECODE.
// Ports:
//   opc   in   4                opcode (IR[15:12])
//   ctrl  out  ctrl_bundle_t    decoded strobe bundle
module acc_ctrl_decode
    import acc_pkg::*;
(
    input  logic [3:0]   opc,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (opc)
            OPC_NOP: ;
            OPC_LDI: begin
                ctrl.acc_load = 1'b1;
                ctrl.acc_src  = ACC_SRC_IMM;
            end
            OPC_LD: begin
                ctrl.go_mem   = 1'b1;
                ctrl.mem_load = 1'b1;
            end
            OPC_ST: begin
                ctrl.go_mem = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
                ctrl.acc_load = 1'b1;
                ctrl.acc_src  = ACC_SRC_ALU;
                ctrl.alu_op   = alu_op_of(opc);
            end
            OPC_MOVR: ctrl.reg_we = 1'b1;
            OPC_MOVA: begin
                ctrl.acc_load = 1'b1;
                ctrl.acc_src  = ACC_SRC_REG;
            end
            OPC_BEQZ: ctrl.pc_load_if_zero = 1'b1;
            OPC_JMP:  ctrl.pc_load = 1'b1;
            OPC_IN: begin
                ctrl.acc_load = 1'b1;
                ctrl.acc_src  = ACC_SRC_IMM;
                ctrl.in_sel   = 1'b1;
            end
            OPC_OUT:  ctrl.out_load = 1'b1;
            OPC_ILL:  ctrl.illegal = 1'b1;
            OPC_HALT: ctrl.go_halt = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/acc_control_unit.sv
// Multi-cycle control FSM for the 16-bit multi-register accumulator processor.
// Fetches instructions over a req/ready handshake, decodes them and sequences
// the datapath (PC, IR, ACC, register file, ALU, output latch).
// State flow: FETCH -> DECODE -> EXEC -> (MEM ->) FETCH, or HALT (reset only exit).
// Ports:
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   instr      in   DATA_W     memory read data {opc, rsel, imm}
//   mem_ready  in   1          memory completes the current access
//   zero_flag  in   1          accumulator == 0
//   mem_req    out  1          memory access request
//   mem_we     out  1          write qualifier (with mem_req)
//   addr_sel   out  1          0 = PC, 1 = imm drives the address
//   ir_load    out  1          IR <= instr
//   pc_inc     out  1          PC <= PC + 1
//   pc_load    out  1          PC <= imm
//   acc_load   out  1          ACC <= selected source
//   acc_src    out  2          ACC source select (ACC_SRC_*)
//   alu_op     out  3          ALU operation (ALU_*)
//   reg_we     out  1          R[reg_sel] <= ACC
//   reg_sel    out  REG_SEL_W  register select, IR[11:8]
//   out_load   out  1          Output_Data <= ACC
//   in_sel     out  1          ACC imm source takes Input_Data
//   halted     out  1          sticky, high in HALT
//   illegal    out  1          one-cycle pulse on undefined opcode
//   bus_error  out  1          sticky, handshake timeout
module acc_control_unit
    import acc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_SEL_W = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    instr,
    input  logic                 mem_ready,
    input  logic                 zero_flag,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 acc_load,
    output logic [1:0]           acc_src,
    output logic [2:0]           alu_op,
    output logic                 reg_we,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 out_load,
    output logic                 in_sel,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_error
);

    // Only the opcode and register select are needed here; the immediate
    // lives in the datapath's own copy of IR.
    localparam int IR_W = 4 + REG_SEL_W;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [IR_W-1:0]     ir_reg, ir_next;
    ctrl_bundle_t        dec_reg, dec_next;
    ctrl_bundle_t        dec_bundle;
    logic [7:0]          wait_cnt_reg, wait_cnt_next;
    logic                bus_error_reg, bus_error_next;
    logic                wait_expired;
    logic [DATA_W-IR_W-1:0] unused_imm;

    assign unused_imm = instr[DATA_W-IR_W-1:0];

    acc_ctrl_decode u_decode (
        .opc  (ir_reg[IR_W-1 -: 4]),
        .ctrl (dec_bundle)
    );

    // This cycle is the TIMEOUT-th consecutive cycle without mem_ready
    assign wait_expired = !mem_ready && (wait_cnt_reg == WAIT_LAST);

    assign reg_sel   = ir_reg[REG_SEL_W-1:0];
    assign halted    = (state_reg == ST_HALT);
    assign bus_error = bus_error_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            ir_reg        <= '0;
            dec_reg       <= '0;
            wait_cnt_reg  <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ir_reg        <= ir_next;
            dec_reg       <= dec_next;
            wait_cnt_reg  <= wait_cnt_next;
            bus_error_reg <= bus_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ir_next        = ir_reg;
        dec_next       = dec_reg;
        wait_cnt_next  = wait_cnt_reg;
        bus_error_next = bus_error_reg;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        addr_sel       = 1'b0;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        acc_load       = 1'b0;
        acc_src        = ACC_SRC_ALU;
        alu_op         = ALU_ADD;
        reg_we         = 1'b0;
        out_load       = 1'b0;
        in_sel         = 1'b0;
        illegal        = 1'b0;

        // Gating on rst_n makes mem_req and every strobe drop the moment
        // reset is asserted, without waiting for a clock edge.
        if (rst_n) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        pc_inc     = 1'b1;
                        ir_next    = instr[DATA_W-1 -: IR_W];
                        state_next = ST_DECODE;
                    end else if (wait_expired) begin
                        bus_error_next = 1'b1;
                        state_next     = ST_HALT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end

                ST_DECODE: begin
                    dec_next   = dec_bundle;
                    state_next = ST_EXEC;
                end

                ST_EXEC: begin
                    acc_load = dec_reg.acc_load;
                    acc_src  = dec_reg.acc_src;
                    alu_op   = dec_reg.alu_op;
                    reg_we   = dec_reg.reg_we;
                    out_load = dec_reg.out_load;
                    in_sel   = dec_reg.in_sel;
                    illegal  = dec_reg.illegal;
                    pc_load  = dec_reg.pc_load
                             | (dec_reg.pc_load_if_zero & zero_flag);
                    if (dec_reg.go_mem) begin
                        wait_cnt_next = '0;
                        state_next    = ST_MEM;
                    end else if (dec_reg.go_halt) begin
                        state_next = ST_HALT;
                    end else begin
                        wait_cnt_next = '0;
                        state_next    = ST_FETCH;
                    end
                end

                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = dec_reg.mem_we;
                    if (mem_ready) begin
                        acc_load      = dec_reg.mem_load;
                        acc_src       = dec_reg.mem_load ? ACC_SRC_MEM : ACC_SRC_ALU;
                        wait_cnt_next = '0;
                        state_next    = ST_FETCH;
                    end else if (wait_expired) begin
                        // Abandon the access; the LD load strobe never fires
                        bus_error_next = 1'b1;
                        state_next     = ST_HALT;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end

                ST_HALT: ;

                default: state_next = ST_FETCH;
            endcase
        end
    end

endmodule
